// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO writes.
// Operands are reduced to magnitudes at launch; the sign is restored in the final FIX cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo, rem;

    assign signed_op = ~op[0];
    assign a_mag     = abs_w(a, signed_op);
    assign b_mag     = abs_w(b, signed_op);

    // Multiply: acc = {partial, multiplier}; add multiplicand on the low bit, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift in one dividend bit, trial-subtract.
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_part - {1'b0, opnd_q};
    assign div_ge   = (div_part >= {1'b0, opnd_q});
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

    assign quo = acc_q[WIDTH-1:0];
    assign rem = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dz_d       = dz_q;

        unique case (state_q)
            StIdle: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !cancel) begin
                    state_d    = StRun;
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    opnd_d     = op[1] ? b_mag : a_mag;
                    neg_d      = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d  = signed_op & a[WIDTH-1];
                    div_zero_d = op[1] & (b == '0);
                    dz_d       = 1'b0;
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    done_d = 1'b1;
                    dz_d   = div_zero_q;
                    if (is_div_q) begin
                        // Divide by zero: remainder path already reproduces a; quotient forced.
                        lo_d = div_zero_q ? '1 : neg_w(quo, neg_q);
                        hi_d = neg_w(rem, rem_neg_q);
                    end else begin
                        {hi_d, lo_d} = neg_2w(acc_q, neg_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference result of one operation from plain integer arithmetic.
    function automatic void model_op(input logic [1:0] mop, input logic [W-1:0] ma,
                                     input logic [W-1:0] mb, output logic [W-1:0] rh,
                                     output logic [W-1:0] rl, output logic rdz);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        rdz = 1'b0;
        case (mop)
            MDU_MULT:  p = 64'(sa * sb);
            MDU_MULTU: p = {32'b0, ma} * {32'b0, mb};
            default:   p = '0;
        endcase
        rh = p[63:32];
        rl = p[31:0];
        if (mop[1]) begin
            if (mb == '0) begin
                rl  = '1;
                rh  = ma;
                rdz = 1'b1;
            end else if (mop == MDU_DIV) begin
                q  = sa / sb;
                r  = sa % sb;
                rl = q[31:0];
                rh = r[31:0];
            end else begin
                rl = ma / mb;
                rh = ma % mb;
            end
        end
    endfunction

    // Cycle model: an accepted op occupies W+1 busy cycles, then commits its result.
    logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
    logic         m_dz, m_done, r_dz;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_dz   = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (cancel) begin
                    m_left = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_hi   = r_hi;
                        m_lo   = r_lo;
                        m_dz   = r_dz;
                        m_done = 1'b1;
                    end
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start && !cancel) begin
                    model_op(op, a, b, r_hi, r_lo, r_dz);
                    m_dz   = 1'b0;
                    m_left = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_bit("cyc_busy", busy, m_left > 0);
            check_bit("cyc_done", done, m_done);
            check_bit("cyc_dz", dz, m_dz);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] sop, input logic [W-1:0] sa,
                               input logic [W-1:0] sb);
        start = 1'b1;
        op    = sop;
        a     = sa;
        b     = sb;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int busy_cycles);
        bit seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            tick();
        end
        check_bit({name, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic run_op(input string name, input logic [1:0] sop, input logic [W-1:0] sa,
                          input logic [W-1:0] sb, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_dz);
        int nb;
        pulse_start(sop, sa, sb);
        wait_done(name, nb);
        check({name, "_busy_cycles"}, W'(nb), W'(W + 1));
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check_bit({name, "_dz"}, dz, exp_dz);
        tick();
        check_bit({name, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int  nb;
        bit  saw_done;

        tick();
        tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_dz", dz, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst = 1'b0;
        tick();

        run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_negb", MDU_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
        run_op("divu_zero", MDU_DIVU, 32'd100, 32'h0, 32'h00000064, 32'hFFFFFFFF, 1);
        run_op("div_zero_neg", MDU_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
        run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("divu_big", MDU_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 0);
        run_op("mult_min", MDU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0);
        run_op("multu_16", MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h0, 0);

        // Start while busy is ignored; start in the done cycle is accepted.
        pulse_start(MDU_MULTU, 32'd3, 32'd5);
        repeat (5) tick();
        pulse_start(MDU_MULTU, 32'd7, 32'd7);
        wait_done("ign_start", nb);
        check("ign_start_lo", lo, 32'd15);
        check("ign_start_hi", hi, 32'd0);
        pulse_start(MDU_DIVU, 32'd100, 32'd7);
        check_bit("b2b_busy", busy, 1'b1);
        wait_done("b2b", nb);
        check("b2b_lo", lo, 32'd14);
        check("b2b_hi", hi, 32'd2);
        tick();

        // lo_we while busy ignored; cancel discards the op.
        pulse_start(MDU_MULT, 32'd5, 32'd6);
        repeat (3) tick();
        lo_we = 1'b1;
        wdata = 32'hDEADBEEF;
        tick();
        lo_we = 1'b0;
        repeat (5) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_bit("cancel_busy", busy, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            saw_done |= done;
            tick();
        end
        check_bit("cancel_no_done", saw_done, 1'b0);
        check("cancel_hi", hi, 32'd2);
        check("cancel_lo", lo, 32'd14);

        lo_we = 1'b1;
        wdata = 32'hCAFEF00D;
        tick();
        lo_we = 1'b0;
        check("mtlo", lo, 32'hCAFEF00D);
        hi_we = 1'b1;
        wdata = 32'h12345678;
        tick();
        hi_we = 1'b0;
        check("mthi", hi, 32'h12345678);

        // Start with cancel in the same idle cycle is ignored.
        cancel = 1'b1;
        pulse_start(MDU_MULTU, 32'd9, 32'd9);
        cancel = 1'b0;
        check_bit("start_cancel_busy", busy, 1'b0);

        // MTHI and start on the same edge: write lands, op overwrites later.
        hi_we = 1'b1;
        wdata = 32'h55555555;
        pulse_start(MDU_MULTU, 32'd2, 32'd3);
        hi_we = 1'b0;
        check("mt_start_hi", hi, 32'h55555555);
        wait_done("mt_start", nb);
        check("mt_start_hi_final", hi, 32'd0);
        check("mt_start_lo_final", lo, 32'd6);
        tick();

        // Asynchronous reset mid-RUN.
        pulse_start(MDU_MULTU, 32'd9, 32'd9);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check_bit("arst_busy", busy, 1'b0);
        check_bit("arst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset clears a held dz flag.
        run_op("divu_zero2", MDU_DIVU, 32'd5, 32'h0, 32'd5, 32'hFFFFFFFF, 1);
        #2 rst = 1'b1;
        #1;
        check_bit("arst_dz", dz, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
